// File: rtl/uart_wb_host_if.sv
// uart_wb_host_if
// Bundles the three handshakes around the UART Wishbone host:
//   command stream  : cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_addr_i[2:0], cmd_wdata_i[7:0]
//   response stream : rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_rdata_o[7:0], rsp_err_o
//   Wishbone bus    : wb_addr_o[2:0], wb_dat_o[7:0], wb_dat_i[7:0], wb_we_o, wb_sel_o[3:0],
//                     wb_stb_o, wb_cyc_o, wb_ack_i
// Signal suffixes are named from the host's point of view.
// Modports:
//   master : the host itself (drives cmd_ready, rsp_*, wb_* outputs)
//   slave  : the environment (command source, response sink and UART slave)

interface uart_wb_host_if;

    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_we_i;
    logic [2:0] cmd_addr_i;
    logic [7:0] cmd_wdata_i;

    logic       rsp_valid_o;
    logic       rsp_ready_i;
    logic       rsp_we_o;
    logic [7:0] rsp_rdata_o;
    logic       rsp_err_o;

    logic [2:0] wb_addr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic [3:0] wb_sel_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic       wb_ack_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_ready_i,
        input  wb_dat_i, wb_ack_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_err_o,
        output wb_addr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_wdata_i,
        output rsp_ready_i,
        output wb_dat_i, wb_ack_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_we_o, rsp_rdata_o, rsp_err_o,
        input  wb_addr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
    );

endinterface

// File: rtl/uart_wb_host.sv
// uart_wb_host
// Wishbone single-cycle master in front of the UART 16550 register port. Turns one
// valid/ready register command into one Wishbone cycle and returns the result on a
// valid/ready response stream. Also synchronises the UART interrupt line.
//
// Ports:
//   wb_clk_i       clock, all logic on the rising edge
//   wb_rst_i       synchronous active-high reset
//   bus            uart_wb_host_if.master (command, response and Wishbone signals)
//   int_i          UART interrupt, asynchronous to wb_clk_i
//   int_sync_o     int_i after a two-flop synchroniser
//   spurious_ack_o one-cycle pulse when wb_ack_i arrives with no cycle in progress
//
// Parameters:
//   TIMEOUT_CYCLES bus cycles to wait for wb_ack_i before aborting (>= 2)
//   TCNT_W         timeout counter width, 2**TCNT_W > TIMEOUT_CYCLES
//
// Build option:
//   UART_WB_TIMEOUT_EN  when defined, a cycle with no ack is aborted after
//                       TIMEOUT_CYCLES bus cycles and reported with rsp_err_o=1.
//                       When undefined, the host waits for ack indefinitely and
//                       rsp_err_o stays 0; TIMEOUT_CYCLES/TCNT_W then have no effect.

module uart_wb_host #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TCNT_W         = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    uart_wb_host_if.master        bus,
    input  logic                  int_i,
    output logic                  int_sync_o,
    output logic                  spurious_ack_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t state;

    // Empty marker block that only elaborates for a configuration whose counter
    // could never reach TIMEOUT_CYCLES-1, making a bad parameter set visible in
    // the elaborated hierarchy.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES >= (64'd1 << TCNT_W)) begin : g_bad_timeout_config
    end

`ifdef UART_WB_TIMEOUT_EN
    localparam logic [TCNT_W-1:0] TCOUNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
    logic [TCNT_W-1:0] tcount;
`endif

    // Command/bus/response sequencer. The Wishbone outputs double as the latched
    // copy of the accepted command, so they stay stable for the whole BUS state.
    // The response is registered on the ack (or timeout) edge and held until the
    // sink takes it; cmd_ready_o only returns on the edge after consumption, so a
    // new command can never be accepted in the same cycle a response leaves.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state           <= IDLE;
            bus.cmd_ready_o <= 1'b1;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_we_o    <= 1'b0;
            bus.rsp_rdata_o <= 8'h00;
            bus.rsp_err_o   <= 1'b0;
            bus.wb_cyc_o    <= 1'b0;
            bus.wb_stb_o    <= 1'b0;
            bus.wb_we_o     <= 1'b0;
            bus.wb_addr_o   <= 3'd0;
            bus.wb_dat_o    <= 8'h00;
            bus.wb_sel_o    <= 4'h0;
            spurious_ack_o  <= 1'b0;
`ifdef UART_WB_TIMEOUT_EN
            tcount          <= '0;
`endif
        end else begin
            // An ack is only meaningful while a cycle is on the bus.
            spurious_ack_o <= bus.wb_ack_i && (state != BUS);

            case (state)
                IDLE: begin
                    bus.cmd_ready_o <= 1'b1;
                    if (bus.cmd_valid_i) begin
                        bus.cmd_ready_o <= 1'b0;
                        bus.wb_cyc_o    <= 1'b1;
                        bus.wb_stb_o    <= 1'b1;
                        bus.wb_sel_o    <= 4'hF;
                        bus.wb_we_o     <= bus.cmd_we_i;
                        bus.wb_addr_o   <= bus.cmd_addr_i;
                        bus.wb_dat_o    <= bus.cmd_we_i ? bus.cmd_wdata_i : 8'h00;
                        state           <= BUS;
                    end
                end

                BUS: begin
                    if (bus.wb_ack_i) begin
                        // Ack takes priority over a timeout landing on the same cycle.
                        bus.wb_cyc_o    <= 1'b0;
                        bus.wb_stb_o    <= 1'b0;
                        bus.wb_sel_o    <= 4'h0;
                        bus.rsp_valid_o <= 1'b1;
                        bus.rsp_we_o    <= bus.wb_we_o;
                        bus.rsp_rdata_o <= bus.wb_we_o ? 8'h00 : bus.wb_dat_i;
                        bus.rsp_err_o   <= 1'b0;
                        state           <= RESP;
                    end
`ifdef UART_WB_TIMEOUT_EN
                    else begin
                        tcount <= tcount + 1'b1;
                        if (tcount == TCOUNT_LAST) begin
                            bus.wb_cyc_o    <= 1'b0;
                            bus.wb_stb_o    <= 1'b0;
                            bus.wb_sel_o    <= 4'h0;
                            bus.rsp_valid_o <= 1'b1;
                            bus.rsp_we_o    <= bus.wb_we_o;
                            bus.rsp_rdata_o <= 8'h00;
                            bus.rsp_err_o   <= 1'b1;
                            state           <= RESP;
                        end
                    end
`endif
                end

                RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o <= 1'b0;
                        bus.cmd_ready_o <= 1'b1;
                        state           <= IDLE;
`ifdef UART_WB_TIMEOUT_EN
                        tcount          <= '0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the UART interrupt, which is generated from
    // registers that may not share this clock.
    logic int_meta;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            int_meta   <= 1'b0;
            int_sync_o <= 1'b0;
        end else begin
            int_meta   <= int_i;
            int_sync_o <= int_meta;
        end
    end

endmodule

// File: tb/tb_uart_wb_host.sv
// tb_uart_wb_host
// Self-checking bench for uart_wb_host. The bench plays command source, response
// sink and UART Wishbone slave. Inputs are driven and outputs sampled on the
// falling clock edge. Expected responses come from a transaction-level model:
// each command's outcome (echo of we, read data or zero, timeout flag) is derived
// from the command and the number of wait states the slave inserts.

module tb_uart_wb_host;

    localparam int TO = 64;

`ifdef UART_WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic       we;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic int_i;
    logic int_sync;
    logic spurious;

    int checks = 0;
    int errors = 0;

    rsp_t expected_q[$];
    logic int_hist[$];

    uart_wb_host_if bus_if ();

    uart_wb_host #(
        .TIMEOUT_CYCLES (TO),
        .TCNT_W         (8)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .bus            (bus_if),
        .int_i          (int_i),
        .int_sync_o     (int_sync),
        .spurious_ack_o (spurious)
    );

    always #5 clk = ~clk;

    // Hard stop in case something outside the bounded loops wedges the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish before 500us");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Outcome of one command: a timeout happens when the slave would need more
    // than TO bus cycles to ack; writes and timeouts return zero data.
    function automatic rsp_t model(input logic we, input logic [7:0] rdata, input int waits);
        rsp_t r;
        r.we    = we;
        r.err   = TO_EN && (waits >= TO);
        r.rdata = (we || r.err) ? 8'h00 : rdata;
        return r;
    endfunction

    // Checks the registered response, holds it under backpressure for rsp_delay
    // cycles while a competing command waits, then consumes it.
    task automatic finishResponse(input int rsp_delay);
        rsp_t exp;
        exp = expected_q.pop_front();
        checkOutput("bus_release", {bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_sel_o}, 32'h0);
        checkOutput("rsp", {bus_if.rsp_valid_o, bus_if.rsp_we_o, bus_if.rsp_err_o, bus_if.rsp_rdata_o},
                    {1'b1, exp.we, exp.err, exp.rdata});
        bus_if.rsp_ready_i = 1'b0;
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = 1'($urandom);
        bus_if.cmd_addr_i  = 3'($urandom);
        bus_if.cmd_wdata_i = 8'($urandom);
        for (int i = 0; i < rsp_delay; i++) begin
            tick();
            checkOutput("rsp_hold", {bus_if.rsp_valid_o, bus_if.rsp_we_o, bus_if.rsp_err_o, bus_if.rsp_rdata_o},
                        {1'b1, exp.we, exp.err, exp.rdata});
            checkOutput("cmd_blocked", {bus_if.cmd_ready_o, bus_if.wb_cyc_o}, 32'h0);
        end
        bus_if.rsp_ready_i = 1'b1;
        tick();
        bus_if.rsp_ready_i = 1'b0;
        bus_if.cmd_valid_i = 1'b0;
        checkOutput("rsp_consumed", {bus_if.rsp_valid_o, bus_if.cmd_ready_o, bus_if.wb_cyc_o}, 32'b010);
    endtask

    // One complete command with the slave acking after 'waits' wait states.
    task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] rdata, input int waits, input int rsp_delay);
        int stb_cycles;
        expected_q.push_back(model(we, rdata, waits));
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = we;
        bus_if.cmd_addr_i  = addr;
        bus_if.cmd_wdata_i = wdata;
        checkOutput("cmd_ready_idle", bus_if.cmd_ready_o, 32'h1);
        tick();
        bus_if.cmd_valid_i = 1'b0;
        stb_cycles = 0;
        for (int i = 0; i <= waits; i++) begin
            checkOutput("wb_req", {bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_sel_o,
                                   bus_if.wb_addr_o, bus_if.wb_dat_o},
                        {2'b11, we, 4'hF, addr, (we ? wdata : 8'h00)});
            checkOutput("cmd_ready_bus", bus_if.cmd_ready_o, 32'h0);
            if (bus_if.wb_stb_o === 1'b1) stb_cycles++;
            bus_if.wb_ack_i = (i == waits);
            bus_if.wb_dat_i = (i == waits) ? rdata : 8'($urandom);
            tick();
        end
        bus_if.wb_ack_i = 1'b0;
        bus_if.wb_dat_i = 8'($urandom);
        checkOutput("stb_cycles", stb_cycles, waits + 1);
        finishResponse(rsp_delay);
    endtask

    logic       r_we;
    logic [2:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    int         r_waits;
    int         r_delay;
    int         to_count;

    initial begin
        rst                = 1'b1;
        int_i              = 1'b0;
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_we_i    = 1'b0;
        bus_if.cmd_addr_i  = 3'd0;
        bus_if.cmd_wdata_i = 8'h00;
        bus_if.rsp_ready_i = 1'b0;
        bus_if.wb_dat_i    = 8'h00;
        bus_if.wb_ack_i    = 1'b0;
        repeat (3) tick();

        $display("[TB] reset values");
        checkOutput("reset_cmd_ready", bus_if.cmd_ready_o, 32'h1);
        checkOutput("reset_rsp", {bus_if.rsp_valid_o, bus_if.rsp_we_o, bus_if.rsp_err_o, bus_if.rsp_rdata_o}, 32'h0);
        checkOutput("reset_wb", {bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_sel_o,
                                 bus_if.wb_addr_o, bus_if.wb_dat_o}, 32'h0);
        checkOutput("reset_misc", {int_sync, spurious}, 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 3'd3, 8'h83, 8'h5A, 0, 0);
        applyStimulus(1'b0, 3'd5, 8'hC3, 8'h60, 3, 0);
        applyStimulus(1'b0, 3'd2, 8'h00, 8'hA7, 1, 10);
        applyStimulus(1'b1, 3'd1, 8'h11, 8'hEE, 0, 0);
        applyStimulus(1'b0, 3'd6, 8'h22, 8'h3C, 2, 0);
        applyStimulus(1'b0, 3'd7, 8'h33, 8'hF0, 0, 0);

        $display("[TB] random transactions");
        for (int n = 0; n < 24; n++) begin
            r_we    = 1'($urandom);
            r_addr  = 3'($urandom);
            r_wdata = 8'($urandom);
            r_rdata = 8'($urandom);
            r_waits = int'($urandom_range(0, 5));
            r_delay = int'($urandom_range(0, 3));
            applyStimulus(r_we, r_addr, r_wdata, r_rdata, r_waits, r_delay);
        end

`ifdef UART_WB_TIMEOUT_EN
        $display("[TB] ack on the last allowed cycle");
        applyStimulus(1'b0, 3'd4, 8'h00, 8'h9B, TO - 1, 1);

        $display("[TB] timeout");
        expected_q.push_back(model(1'b0, 8'h77, TO));
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = 1'b0;
        bus_if.cmd_addr_i  = 3'd5;
        bus_if.cmd_wdata_i = 8'h00;
        tick();
        bus_if.cmd_valid_i = 1'b0;
        to_count = 0;
        for (int i = 0; i < TO + 10; i++) begin
            if (bus_if.wb_stb_o !== 1'b1) break;
            to_count++;
            bus_if.wb_dat_i = 8'h77;
            tick();
        end
        checkOutput("timeout_stb_cycles", to_count, TO);
        finishResponse(2);
        applyStimulus(1'b1, 3'd0, 8'h41, 8'h00, 1, 0);
`else
        $display("[TB] long wait without timeout");
        applyStimulus(1'b0, 3'd5, 8'h00, 8'h6D, TO + 6, 1);
`endif

        $display("[TB] spurious ack");
        bus_if.wb_ack_i = 1'b1;
        bus_if.wb_dat_i = 8'hAB;
        tick();
        bus_if.wb_ack_i = 1'b0;
        checkOutput("spurious_pulse", {spurious, bus_if.rsp_valid_o, bus_if.wb_cyc_o}, 32'b100);
        tick();
        checkOutput("spurious_clear", {spurious, bus_if.rsp_valid_o, bus_if.wb_cyc_o}, 32'b000);

        $display("[TB] reset during bus cycle");
        int_i = 1'b1;
        tick();
        tick();
        checkOutput("int_high_before_reset", int_sync, 32'h1);
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = 1'b1;
        bus_if.cmd_addr_i  = 3'd2;
        bus_if.cmd_wdata_i = 8'h5C;
        tick();
        bus_if.cmd_valid_i = 1'b0;
        checkOutput("bus_before_reset", {bus_if.wb_cyc_o, bus_if.wb_stb_o}, 32'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("bus_after_reset", {bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.rsp_valid_o, bus_if.cmd_ready_o},
                    32'b0001);
        checkOutput("int_after_reset", int_sync, 32'h0);
        int_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("no_rsp_after_reset", {bus_if.rsp_valid_o, bus_if.wb_cyc_o}, 32'h0);
        end
        applyStimulus(1'b0, 3'd3, 8'h00, 8'h1F, 2, 0);

        $display("[TB] interrupt synchroniser");
        int_i = 1'b1;
        tick();
        checkOutput("int_rise_1", int_sync, 32'h0);
        tick();
        checkOutput("int_rise_2", int_sync, 32'h1);
        int_i = 1'b0;
        tick();
        checkOutput("int_fall_1", int_sync, 32'h1);
        tick();
        checkOutput("int_fall_2", int_sync, 32'h0);
        int_hist.push_back(1'b0);
        int_hist.push_back(1'b0);
        for (int i = 0; i < 30; i++) begin
            int_i = 1'($urandom);
            int_hist.push_back(int_i);
            tick();
            checkOutput("int_random", int_sync, 32'(int_hist[int_hist.size() - 2]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
